// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared mode enum, bar colour table and default 640x480@60 timing
package vga_pkg;

    typedef enum logic [1:0] {
        SOLID    = 2'd0,
        BARS     = 2'd1,
        CHECKER  = 2'd2,
        GRADIENT = 2'd3
    } mode_e;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    // {r,g,b} per bar, left to right; each bit is replicated to the channel width
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] c;
        case (idx)
            3'd0:    c = 3'b111;
            3'd1:    c = 3'b110;
            3'd2:    c = 3'b011;
            3'd3:    c = 3'b010;
            3'd4:    c = 3'b101;
            3'd5:    c = 3'b100;
            3'd6:    c = 3'b001;
            default: c = 3'b000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// rtl/vga_pattern_gen_if.sv - pattern control inputs and VGA pin outputs
interface vga_pattern_gen_if #(
    parameter int COLOR_W = 4
);
    logic [1:0]           mode;
    logic [3*COLOR_W-1:0] solid_rgb;
    logic [COLOR_W-1:0]   vga_r;
    logic [COLOR_W-1:0]   vga_g;
    logic [COLOR_W-1:0]   vga_b;
    logic                 vga_hs;
    logic                 vga_vs;
    logic                 video_on;
    logic                 frame_start;

    modport master (
        input  mode, solid_rgb,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs, video_on, frame_start
    );

    modport slave (
        output mode, solid_rgb,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs, video_on, frame_start
    );
endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - h/v counters, sync decode and active-area flag
module vga_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0,
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic [HW-1:0] h_cnt_o,
    output logic [VW-1:0] v_cnt_o,
    output logic          active_o,
    output logic          hs_o,
    output logic          vs_o
);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS   = HW'(H_VISIBLE);
    localparam logic [VW-1:0] V_VIS   = VW'(V_VISIBLE);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END  = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END  = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          hs_act, vs_act;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_comb begin
        h_cnt_d = h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
        end
    end

    assign hs_act   = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    assign vs_act   = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    assign hs_o     = hs_act ? SYNC_POL : ~SYNC_POL;
    assign vs_o     = vs_act ? SYNC_POL : ~SYNC_POL;
    assign active_o = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign h_cnt_o  = h_cnt_q;
    assign v_cnt_o  = v_cnt_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - VGA timing plus SOLID/BARS/CHECKER/GRADIENT patterns
// Optional horizontal scrolling of BARS/CHECKER under VGA_PATTERN_SCROLL_EN.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter bit SYNC_POL  = 1'b0,
    parameter int COLOR_W   = 4
) (
    input  logic                clk_25,
    input  logic                rst,
    vga_pattern_gen_if.master   vif
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_VISIBLE / 8;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active, hs, vs, at_origin;
    logic [HW-1:0] x_eff;

    mode_e                mode_q, mode_d;
    logic [3*COLOR_W-1:0] solid_q, solid_d;
    logic [COLOR_W-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
    logic                 hs_q, vs_q, video_on_q, frame_start_q;
    logic [2:0]           rgb3;
    int                   bar_idx;

    vga_timing #(
        .H_VISIBLE (H_VISIBLE), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
        .V_VISIBLE (V_VISIBLE), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK),
        .SYNC_POL  (SYNC_POL)
    ) u_timing (
        .clk_i    (clk_25),
        .rst_i    (rst),
        .h_cnt_o  (h_cnt),
        .v_cnt_o  (v_cnt),
        .active_o (active),
        .hs_o     (hs),
        .vs_o     (vs)
    );

    assign at_origin = (h_cnt == '0) && (v_cnt == '0);

    // Pixel (0,0) already uses the freshly sampled settings so a frame never mixes two modes
    always_comb begin
        mode_d  = mode_q;
        solid_d = solid_q;
        if (at_origin) begin
            mode_d  = mode_e'(vif.mode);
            solid_d = vif.solid_rgb;
        end
    end

`ifdef VGA_PATTERN_SCROLL_EN
    localparam logic [HW:0] H_VIS_X = (HW+1)'(H_VISIBLE);
    logic [HW-1:0] scroll_q, scroll_d;
    logic [HW:0]   x_sum;
    logic          at_last;

    assign at_last = (h_cnt == HW'(H_TOTAL - 1)) && (v_cnt == VW'(V_TOTAL - 1));

    // Scroll steps on the edge that enters a new frame, so each frame sees one value
    always_comb begin
        scroll_d = scroll_q;
        if (at_last) begin
            scroll_d = (scroll_q == HW'(H_VISIBLE - 1)) ? '0 : scroll_q + HW'(1);
        end
        x_sum = {1'b0, h_cnt} + {1'b0, scroll_q};
        x_eff = (x_sum >= H_VIS_X) ? HW'(x_sum - H_VIS_X) : HW'(x_sum);
    end

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) scroll_q <= '0;
        else     scroll_q <= scroll_d;
    end
`else
    assign x_eff = h_cnt;
`endif

    always_comb begin
        r_d     = '0;
        g_d     = '0;
        b_d     = '0;
        rgb3    = 3'b000;
        bar_idx = int'(x_eff) / BAR_W;
        if (bar_idx > 7) bar_idx = 7;
        if (active) begin
            unique case (mode_d)
                SOLID: begin
                    r_d = solid_d[3*COLOR_W-1 -: COLOR_W];
                    g_d = solid_d[2*COLOR_W-1 -: COLOR_W];
                    b_d = solid_d[COLOR_W-1:0];
                end
                BARS:     rgb3 = bar_rgb(3'(bar_idx));
                CHECKER:  rgb3 = {3{1'(x_eff >> 5) ^ 1'(v_cnt >> 5)}};
                GRADIENT: begin
                    r_d = COLOR_W'(h_cnt >> 4);
                    g_d = COLOR_W'(v_cnt >> 4);
                end
            endcase
            if (mode_d == BARS || mode_d == CHECKER) begin
                r_d = {COLOR_W{rgb3[2]}};
                g_d = {COLOR_W{rgb3[1]}};
                b_d = {COLOR_W{rgb3[0]}};
            end
        end
    end

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            mode_q        <= SOLID;
            solid_q       <= '0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            hs_q          <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            solid_q       <= solid_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            hs_q          <= hs;
            vs_q          <= vs;
            video_on_q    <= active;
            frame_start_q <= at_origin;
        end
    end

    assign vif.vga_r       = r_q;
    assign vif.vga_g       = g_q;
    assign vif.vga_b       = b_q;
    assign vif.vga_hs      = hs_q;
    assign vif.vga_vs      = vs_q;
    assign vif.video_on    = video_on_q;
    assign vif.frame_start = frame_start_q;

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Parametrised VGA timing and test-pattern generator for the monitor bring-up designs. It succeeds the fixed 640x480 controller plus single-colour output stage. Timing is generic, colour depth is configurable, and the block offers four runtime-selectable patterns, with optional horizontal scrolling. It sits directly behind the 25 MHz PLL output and drives the VGA pins.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- COLOR_W, 4, bits per colour channel

Ports:
- clk_25  in  1  pixel clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  2  pattern select: 0 SOLID, 1 BARS, 2 CHECKER, 3 GRADIENT
- solid_rgb  in  3*COLOR_W  SOLID colour {r,g,b}
- vga_r / vga_g / vga_b  out  COLOR_W each  colour outputs
- vga_hs / vga_vs  out  1  sync outputs
- video_on  out  1  high while the output pixel is in the active area
- frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

## Operation
- H_TOTAL = sum of the H parameters and V_TOTAL = sum of the V parameters, both compile-time constants.
- The h_cnt counter runs 0..H_TOTAL-1 and then wraps to 0. On that wrap, v_cnt increments over 0..V_TOTAL-1 and wraps.
- Active area: h_cnt < H_VISIBLE and v_cnt < V_VISIBLE.
- hs is active for h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]. vs is active for v_cnt in the equivalent V range.
- The `mode` and `solid_rgb` inputs are sampled only when h_cnt=0 and v_cnt=0, i.e. once per frame. Changes mid-frame never tear the picture.
- SOLID: the output is solid_rgb.
- BARS: 8 bars, each H_VISIBLE/8 wide (integer division). The last bar absorbs any remainder. Left to right: white, yellow, cyan, green, magenta, red, blue, black. "Full" means all ones.
- CHECKER: 32x32 squares. Output is white when x[5]^y[5] = 1, otherwise black.
- GRADIENT: r = x[COLOR_W+3:4], g = y[COLOR_W+3:4], b = 0. Bits above the counter width read as 0.
- Outside the active area all colour outputs are 0.

## Timing
- Latency is one cycle. Every output is registered from the counter state of the previous cycle, so sync, video_on and colour stay mutually aligned.
- Reset values:
  - counters = 0
  - colour = 0
  - vga_hs = vga_vs = ~SYNC_POL
  - video_on = 0
  - frame_start = 0
  - latched mode = SOLID
  - latched colour = 0
  - scroll = 0
- Behaviour after reset release:
  - First edge: outputs reflect (0,0), so video_on = 1 and frame_start = 1.
  - Thereafter one pixel is produced per clock.
- hs period is H_TOTAL clocks with low time H_SYNC. vs period is H_TOTAL*V_TOTAL clocks with width V_SYNC*H_TOTAL.
- Reset asserted mid-frame: all outputs return immediately, asynchronously, to their reset values. After release the frame restarts at (0,0).

## Configuration
- VGA_PATTERN_SCROLL_EN defined:
  - A scroll register counts 0..H_VISIBLE-1. It increments by 1 at every frame start and wraps to 0.
  - BARS and CHECKER use x_eff = x+scroll. H_VISIBLE is subtracted when the sum is >= H_VISIBLE.
  - SOLID and GRADIENT are unaffected.
  - Scroll updates in the same cycle that mode is latched.
- VGA_PATTERN_SCROLL_EN undefined: x_eff = x, and no scroll register exists.

## Structure
- Shared package vga_pkg holds:
  - the mode enum (SOLID, BARS, CHECKER, GRADIENT)
  - a bar colour constant table of 8 3-bit {r,g,b} entries, expanded to COLOR_W by replication
  - the 640x480@60 default timing constants
- Sub-module vga_timing contains the counters, sync decode and active flag, and exports h_cnt, v_cnt and active. The top level adds the pattern logic and the output register.

## Test plan
- Reset check: assert rst mid-line. Outputs are immediately 0 with hs/vs = 1. After release, first cycle shows frame_start = 1 and video_on = 1.
- Default timing: hs low for 96 clocks every 800 clocks. vs low for 1600 clocks every 420000 clocks. video_on high for 640 of 800 clocks.
- BARS with COLOR_W = 4, row 0: x=0 gives F/F/F, x=80 gives F/F/0, x=560 gives 0/0/0, x=639 gives 0/0/0. Blanking gives 0/0/0.
- Mode switch from SOLID to CHECKER at line 100: the rest of the frame stays SOLID. The next frame shows (0,0) black and (32,0) white.
- GRADIENT: x=0x1F0 at y=0x050 gives r=F, g=5, b=0.
- With VGA_PATTERN_SCROLL_EN, BARS:
  - Frame 0, x=79: white.
  - Frame 1, x=79: yellow.
  - After 640 frames, scroll is back to 0.
